axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  Schedules line/word read requests from the instruction cache, data cache and uncached
//  load path onto the single read port of the AXI bridge.
//  - Fixed priority with a starvation override.
//  - Holds any read that hits the line of an in-flight dcache write-back (read-after-write ordering).
//  - Sits between the cache/uncached units and the bridge's d_r* request port.
// PARAMETERS
//  LINE_OFF_W    6    byte-offset bits of a cache line; hazard compare uses addr[31:LINE_OFF_W]
//  STARVE_LIMIT  8    denied cycles after which the oldest waiting requester is forced to top priority
//  CNT_W         4    width of each starvation counter; must hold STARVE_LIMIT
// PORTS
//  aclk          in   1    clock
//  aresetn       in   1    asynchronous, active-low reset
//  i_rvalid      in   1    icache read request, held until i_rready
//  i_raddr       in   32   icache read address
//  i_rlen        in   8    icache AXI burst length (beats-1)
//  i_rready      out  1    icache done pulse, rdata valid this cycle
//  i_rdata       out  512  icache read data
//  d_rvalid/d_raddr/d_rlen/d_rready/d_rdata       same meaning as i_*, dcache requester
//  u_rvalid/u_raddr/u_rlen/u_rready/u_rdata       same meaning as i_*, uncached requester
//  m_rvalid      out  1    request to bridge, held until m_rready
//  m_raddr       out  32   address to bridge
//  m_rlen        out  8    burst length to bridge
//  m_rid         out  2    0 = icache, 1 = dcache, 2 = uncached
//  m_rready      in   1    bridge done pulse
//  m_rdata       in   512  bridge read data, valid with m_rready
//  wb_pending    in   1    dcache write-back in flight (aw issued, b not yet received)
//  wb_addr       in   32   address of the in-flight write-back
// BEHAVIOUR
//  - Reset (async): FSM to IDLE; starvation counters to 0.
//    Outputs m_rvalid=0, m_raddr=0, m_rlen=0, m_rid=0; all *_rready=0, all *_rdata=0.
//  - Reset mid-transfer abandons the grant. The bridge shares aresetn; no replay.
//  - FSM IDLE -> GRANT:
//    - In IDLE, eligible set E = {x : x_rvalid and not hazard(x)}.
//    - hazard(x) = wb_pending && x_raddr[31:LINE_OFF_W] == wb_addr[31:LINE_OFF_W].
//  - Priority when E is non-empty:
//    - If any eligible requester has cnt >= STARVE_LIMIT, grant the one with the largest cnt.
//      Ties break d > u > i.
//    - Otherwise grant in order d > u > i.
//    - Latch id, addr and len into registers; go to GRANT.
//  - FSM GRANT -> IDLE:
//    - In GRANT, m_rvalid=1 and m_raddr/m_rlen/m_rid come from the latched registers.
//    - They stay stable regardless of requester inputs.
//    - On m_rready, route m_rdata and a 1-cycle ready pulse combinationally, same cycle,
//      to the requester selected by latched id. All other *_rready stay 0 and their *_rdata read 0.
//    - Next state is IDLE.
//  - Latency: request seen in IDLE at edge N -> m_rvalid high from cycle N+1.
//    m_rready at cycle M -> x_rready at cycle M.
//    Back-to-back grants: at least 1 IDLE cycle between transactions.
//  - Requester rule: valid deasserts or re-requests no earlier than the cycle after x_rready.
//    Because of the IDLE gap, the just-served requester is never re-granted on stale valid.
//  - Starvation counters, per requester, in IDLE only:
//    - cnt increments (saturating at 2^CNT_W-1) when x_rvalid is high and another requester is granted.
//    - cnt clears when x is granted, or when x_rvalid is low.
//    - A hazard-blocked requester does not count.
//  - Hazard is evaluated only at grant time. wb_pending rising during GRANT does not affect the active read.
//  - All requesters blocked or idle: stay in IDLE with m_rvalid=0.
//  - m_rready while in IDLE is ignored: no pulse forwarded, no state change.
// TESTING
//  1 Simultaneous i/d/u valid, no hazard.
//    -> grants d (m_rid=1), then u (2), then i (0).
//    -> each m_rvalid rises 1 cycle after IDLE; 1 IDLE gap between grants.
//  2 d_raddr=0x1000_0040, wb_pending=1, wb_addr=0x1000_007C; i_rvalid also high.
//    -> icache granted first.
//    -> d is held until wb_pending=0, then granted with m_raddr=0x1000_0040.
//  3 d re-requests continuously; i_rvalid held.
//    -> after i cnt reaches 8, i is granted at the next IDLE despite d_rvalid; i cnt returns to 0.
//  4 In GRANT (id=2), drive m_rready=1 with m_rdata=512'hA5..A5.
//    -> u_rready=1 and u_rdata=A5..A5 in the same cycle; i/d ready and rdata stay 0; IDLE next cycle.
//  5 Assert aresetn=0 mid-GRANT.
//    -> m_rvalid, m_rid and all *_rready go 0 immediately.
//    -> after release, the arbiter re-arbitrates from IDLE with all counters at 0.
//  6 Change i_raddr during GRANT(id=0).
//    -> m_raddr holds the latched value; a stray m_rready in IDLE produces no pulse.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// Read request channel shared by the cache/uncached requesters and the bridge.
// The side that issues a read is the master; the side that completes it is the slave.
// rid is only meaningful on the bridge-facing channel.
interface axi_rd_arbiter_if;
  logic         rvalid;
  logic [31:0]  raddr;
  logic [7:0]   rlen;
  logic [1:0]   rid;
  logic         rready;
  logic [511:0] rdata;

  modport master (
    output rvalid, raddr, rlen, rid,
    input  rready, rdata
  );

  modport slave (
    input  rvalid, raddr, rlen,
    output rready, rdata
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Read arbiter: schedules icache, dcache and uncached read requests onto the single
// bridge read port. Fixed priority d > u > i, with a starvation override that forces
// the longest-waiting requester to the top. A read whose line matches an in-flight
// dcache write-back is held back until the write-back completes.
// Requester index encoding (also the bridge rid): 0 = icache, 1 = dcache, 2 = uncached.
module axi_rd_arbiter #(
  parameter int LINE_OFF_W   = 6,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  axi_rd_arbiter_if.slave     i_req,
  axi_rd_arbiter_if.slave     d_req,
  axi_rd_arbiter_if.slave     u_req,
  axi_rd_arbiter_if.master    m_req,
  input  logic                wb_pending,
  input  logic [31:0]         wb_addr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  state_e           state_q, state_d;
  logic [1:0]       id_q, id_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic             rvalid_q, rvalid_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic             req_valid [3];
  logic [31:0]      req_addr  [3];
  logic [7:0]       req_len   [3];
  logic             hazard    [3];
  logic             eligible  [3];
  logic             starved   [3];
  logic             grant_any;
  logic [1:0]       grant_id;
  logic             fwd;

  // Only the line bits of the write-back address take part in the hazard compare.
  logic             unused_wb_off;
  assign unused_wb_off = ^wb_addr[LINE_OFF_W-1:0];

  // Gather the requesters into index-addressable form and classify each one.
  always_comb begin
    req_valid[0] = i_req.rvalid;
    req_valid[1] = d_req.rvalid;
    req_valid[2] = u_req.rvalid;
    req_addr[0]  = i_req.raddr;
    req_addr[1]  = d_req.raddr;
    req_addr[2]  = u_req.raddr;
    req_len[0]   = i_req.rlen;
    req_len[1]   = d_req.rlen;
    req_len[2]   = u_req.rlen;
    for (int k = 0; k < 3; k++) begin
      hazard[k]   = wb_pending && (req_addr[k][31:LINE_OFF_W] == wb_addr[31:LINE_OFF_W]);
      eligible[k] = req_valid[k] && !hazard[k];
      starved[k]  = eligible[k] && (cnt_q[k] >= CNT_LIMIT);
    end
  end

  // Pick the winner: largest starved counter (ties d > u > i), else fixed d > u > i.
  always_comb begin
    logic [CNT_W-1:0] best_cnt;
    logic             found;
    grant_any = eligible[0] || eligible[1] || eligible[2];
    grant_id  = 2'd0;
    best_cnt  = '0;
    found     = 1'b0;
    if (starved[0] || starved[1] || starved[2]) begin
      if (starved[1]) begin
        grant_id = 2'd1;
        best_cnt = cnt_q[1];
        found    = 1'b1;
      end
      if (starved[2] && (!found || cnt_q[2] > best_cnt)) begin
        grant_id = 2'd2;
        best_cnt = cnt_q[2];
        found    = 1'b1;
      end
      if (starved[0] && (!found || cnt_q[0] > best_cnt)) begin
        grant_id = 2'd0;
      end
    end else if (eligible[1]) begin
      grant_id = 2'd1;
    end else if (eligible[2]) begin
      grant_id = 2'd2;
    end else begin
      grant_id = 2'd0;
    end
  end

  // Next-state logic: latch the winner's request in IDLE, release on bridge completion.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rvalid_d = rvalid_q;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d  = GRANT;
          rvalid_d = 1'b1;
          id_d     = grant_id;
          case (grant_id)
            2'd1:    begin addr_d = req_addr[1]; len_d = req_len[1]; end
            2'd2:    begin addr_d = req_addr[2]; len_d = req_len[2]; end
            default: begin addr_d = req_addr[0]; len_d = req_len[0]; end
          endcase
        end
        for (int k = 0; k < 3; k++) begin
          if (!req_valid[k] || (grant_any && grant_id == 2'(k))) begin
            cnt_d[k] = '0;
          end else if (hazard[k]) begin
            cnt_d[k] = cnt_q[k];
          end else if (grant_any && cnt_q[k] != CNT_MAX) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
      end
      GRANT: begin
        if (m_req.rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
      end
    endcase
  end

  // State, latched request and starvation counters; reset abandons any grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      id_q     <= 2'd0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      rvalid_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rvalid_q <= rvalid_d;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Bridge request comes straight from the latched registers.
  always_comb begin
    m_req.rvalid = rvalid_q;
    m_req.raddr  = addr_q;
    m_req.rlen   = len_q;
    m_req.rid    = id_q;
  end

  // Completion is forwarded in the same cycle, only to the granted requester.
  always_comb begin
    fwd          = (state_q == GRANT) && m_req.rready;
    i_req.rready = fwd && (id_q == 2'd0);
    d_req.rready = fwd && (id_q == 2'd1);
    u_req.rready = fwd && (id_q == 2'd2);
    i_req.rdata  = (fwd && id_q == 2'd0) ? m_req.rdata : '0;
    d_req.rdata  = (fwd && id_q == 2'd1) ? m_req.rdata : '0;
    u_req.rdata  = (fwd && id_q == 2'd2) ? m_req.rdata : '0;
  end

endmodule
